// File: rtl/oam_dma_ctrl.sv
// -----------------------------------------------------------------------------
// oam_dma_ctrl
//
// OAM DMA engine and main-memory-bus arbiter for the SM83 core. It sits between
// the CPU bus-request outputs of the control sequencer and the shared main bus.
//
// A CPU write to DMA_REG_ADDR (0xFF46) latches a source page and starts a
// XFER_LEN-byte copy from {page, 0x00..XFER_LEN-1} into OAM. While the copy
// runs, the engine owns the main bus. CPU accesses below 0xFF00 are blocked:
// writes are dropped and reads return 0xFF. CPU accesses to 0xFF00-0xFFFF are
// always routed to the separate high (IO/HRAM) port. The exception is the DMA
// source register itself, which is decoded here.
//
// Ports
//   clk, rst_n      clock (one clk = one M-cycle); asynchronous active-low reset
//   cpu_addr/rd/wr  CPU request address and strobes
//   cpu_wdata       CPU write data
//   cpu_rdata       read data returned to the CPU (combinational)
//   bus_*           main memory bus; bus_rdata is valid the cycle after bus_rd
//   hi_*            high-page port; hi_addr is the low byte of the CPU address,
//                   hi_rdata is combinational
//   oam_addr/wdata/we  OAM write port (index 0..XFER_LEN-1)
//   dma_active      high while the DMA owns the main bus
//
// Timing of one transfer, where the trigger write is sampled at edge T:
//   T+1          START (START_DELAY idle cycles)
//   T+2..T+161   source reads, one per cycle
//   T+3..T+162   OAM writes, one cycle behind each read
//   T+1..T+162   dma_active
// -----------------------------------------------------------------------------
module oam_dma_ctrl #(
  parameter int unsigned XFER_LEN     = 160,    // bytes copied per DMA (1..256)
  parameter int unsigned START_DELAY  = 1,      // idle cycles before first read (>= 1)
  parameter logic [15:0] DMA_REG_ADDR = 16'hFF46
) (
  input  logic        clk,
  input  logic        rst_n,
  // CPU request side
  input  logic [15:0] cpu_addr,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  // Main memory bus
  output logic [15:0] bus_addr,
  output logic        bus_rd,
  output logic        bus_wr,
  output logic [7:0]  bus_wdata,
  input  logic [7:0]  bus_rdata,
  // High (IO/HRAM) port
  output logic [7:0]  hi_addr,
  output logic        hi_rd,
  output logic        hi_wr,
  output logic [7:0]  hi_wdata,
  input  logic [7:0]  hi_rdata,
  // OAM write port
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_wdata,
  output logic        oam_we,
  // Status
  output logic        dma_active
);

  // ---------------------------------------------------------------------------
  // FSM encoding
  // ---------------------------------------------------------------------------
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_XFER  = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  localparam logic [7:0] LAST_IDX   = 8'(XFER_LEN - 1);
  localparam logic [7:0] START_LAST = 8'(START_DELAY - 1);

  // Echo RAM (0xE000-0xFDFF) mirrors work RAM, so pages at or above 0xE0 fold
  // down by clearing bit 5.
  localparam logic [7:0] ECHO_BASE = 8'hE0;
  localparam logic [7:0] ECHO_MASK = 8'hDF;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0] state_q,    state_d;
  logic [7:0] src_hi_q,   src_hi_d;    // raw value written to the DMA register
  logic [7:0] idx_q,      idx_d;       // source/OAM index of the next read
  logic [7:0] dly_q,      dly_d;       // cycles already spent in START
  logic       pend_q,     pend_d;      // a read was issued last cycle
  logic [7:0] pend_idx_q, pend_idx_d;  // index of that read

  // ---------------------------------------------------------------------------
  // CPU request decode
  // ---------------------------------------------------------------------------
  logic       hit_dma_reg;
  logic       hi_region;
  logic       trigger;
  logic       busy;
  logic       dma_rd;
  logic [7:0] eff_src;

  assign hit_dma_reg = (cpu_addr == DMA_REG_ADDR);
  assign hi_region   = (cpu_addr[15:8] == 8'hFF);
  assign trigger     = cpu_wr & hit_dma_reg;
  assign busy        = (state_q != ST_IDLE);

  // A restart write cancels the read this cycle would have issued. The OAM
  // write of the previous cycle's read still completes, so no byte already
  // fetched is lost, and no orphan write follows into START.
  assign dma_rd  = (state_q == ST_XFER) & ~trigger;
  assign eff_src = (src_hi_q < ECHO_BASE) ? src_hi_q : (src_hi_q & ECHO_MASK);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before any branch, so that no path
    // leaves it unassigned and infers a latch.
    state_d    = state_q;
    src_hi_d   = src_hi_q;
    idx_d      = idx_q;
    dly_d      = dly_q;
    pend_d     = dma_rd;
    pend_idx_d = idx_q;

    if (trigger) begin
      // The trigger wins over every state. Writing the register mid-copy
      // restarts the copy from the beginning with the new page.
      src_hi_d = cpu_wdata;
      state_d  = ST_START;
      idx_d    = 8'd0;
      dly_d    = 8'd0;
    end else begin
      case (state_q)
        ST_START: begin
          if (dly_q == START_LAST) begin
            state_d = ST_XFER;
            idx_d   = 8'd0;
          end else begin
            dly_d = dly_q + 8'd1;
          end
        end
        ST_XFER: begin
          // Hold idx on the last read rather than wrap it.
          if (idx_q == LAST_IDX) begin
            state_d = ST_DRAIN;
          end else begin
            idx_d = idx_q + 8'd1;
          end
        end
        ST_DRAIN: begin
          // The final OAM write is committed in this cycle.
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      src_hi_q   <= 8'hFF;
      idx_q      <= 8'd0;
      dly_q      <= 8'd0;
      pend_q     <= 1'b0;
      pend_idx_q <= 8'd0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments, so every
      // register samples values from before the edge, whatever the
      // statement order.
      state_q    <= state_d;
      src_hi_q   <= src_hi_d;
      idx_q      <= idx_d;
      dly_q      <= dly_d;
      pend_q     <= pend_d;
      pend_idx_q <= pend_idx_d;
    end
  end

  // ---------------------------------------------------------------------------
  // OAM write port: the read issued last cycle returns its data now.
  // ---------------------------------------------------------------------------
  assign oam_we    = pend_q;
  assign oam_addr  = pend_q ? pend_idx_q : 8'd0;
  assign oam_wdata = pend_q ? bus_rdata  : 8'd0;

  assign dma_active = busy;

  // ---------------------------------------------------------------------------
  // Bus routing
  //
  // The CPU path is combinational from the CPU request. It is held quiet while
  // reset is asserted, so that every output reads zero during reset no matter
  // what the sequencer is driving.
  // ---------------------------------------------------------------------------
  always_comb begin
    bus_addr  = 16'd0;
    bus_rd    = 1'b0;
    bus_wr    = 1'b0;
    bus_wdata = 8'd0;
    hi_addr   = 8'd0;
    hi_rd     = 1'b0;
    hi_wr     = 1'b0;
    hi_wdata  = 8'd0;
    cpu_rdata = 8'd0;

    // DMA source read. It only happens while busy, and then the CPU cannot
    // reach the main bus, so the two never collide.
    if (dma_rd) begin
      bus_rd   = 1'b1;
      bus_addr = {eff_src, idx_q};
    end

    if (rst_n) begin
      if (cpu_wr) begin
        // A write takes priority over a simultaneous read.
        if (hi_region && !hit_dma_reg) begin
          hi_wr    = 1'b1;
          hi_addr  = cpu_addr[7:0];
          hi_wdata = cpu_wdata;
        end else if (!hi_region && !busy) begin
          bus_wr    = 1'b1;
          bus_addr  = cpu_addr;
          bus_wdata = cpu_wdata;
        end
        if (cpu_rd) begin
          cpu_rdata = 8'hFF;
        end
      end else if (cpu_rd) begin
        if (hit_dma_reg) begin
          cpu_rdata = src_hi_q;
        end else if (hi_region) begin
          hi_rd     = 1'b1;
          hi_addr   = cpu_addr[7:0];
          cpu_rdata = hi_rdata;
        end else if (busy) begin
          cpu_rdata = 8'hFF;             // main bus is owned by the DMA
        end else begin
          bus_rd    = 1'b1;
          bus_addr  = cpu_addr;
          cpu_rdata = bus_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// -----------------------------------------------------------------------------
// tb_oam_dma_ctrl
//
// Self-checking bench for oam_dma_ctrl. A synchronous main-memory model and a
// combinational high-port model surround the DUT. A negedge monitor logs every
// OAM write, every DMA bus read and every dma_active cycle, each tagged with
// its cycle number. A reference model builds the expected event list of a
// transfer from the trigger cycle and the source page, and each scenario
// compares the logged events with that list.
// -----------------------------------------------------------------------------
module tb_oam_dma_ctrl;

  localparam int XFER = 160;
  localparam int NEVER = 32'h7FFF_FFFF;

  localparam logic [1:0] K_OAM = 2'd0;
  localparam logic [1:0] K_RD  = 2'd1;
  localparam logic [1:0] K_ACT = 2'd2;

  typedef struct packed {
    logic [1:0]  kind;
    logic [31:0] cyc;
    logic [15:0] addr;
    logic [7:0]  data;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] cpu_addr;
  logic        cpu_rd, cpu_wr;
  logic [7:0]  cpu_wdata, cpu_rdata;
  logic [15:0] bus_addr;
  logic        bus_rd, bus_wr;
  logic [7:0]  bus_wdata, bus_rdata;
  logic [7:0]  hi_addr;
  logic        hi_rd, hi_wr;
  logic [7:0]  hi_wdata, hi_rdata;
  logic [7:0]  oam_addr, oam_wdata;
  logic        oam_we, dma_active;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [7:0] mem [0:65535];
  logic [7:0] ref_mem [logic [15:0]];
  ev_t        log_q[$];
  ev_t        exp_q[$];

  logic [69:0] all_outs;
  assign all_outs = {bus_addr, bus_rd, bus_wr, bus_wdata, hi_addr, hi_rd, hi_wr, hi_wdata,
                     oam_addr, oam_wdata, oam_we, dma_active, cpu_rdata};

  oam_dma_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_addr(cpu_addr), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .bus_addr(bus_addr), .bus_rd(bus_rd), .bus_wr(bus_wr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .hi_addr(hi_addr), .hi_rd(hi_rd), .hi_wr(hi_wr),
    .hi_wdata(hi_wdata), .hi_rdata(hi_rdata),
    .oam_addr(oam_addr), .oam_wdata(oam_wdata), .oam_we(oam_we),
    .dma_active(dma_active)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous main memory: read data appears the cycle after bus_rd.
  always @(posedge clk) begin
    if (bus_wr) mem[bus_addr] <= bus_wdata;
    if (bus_rd) bus_rdata <= mem[bus_addr];
  end

  // High port returns a fixed pattern of its address.
  assign hi_rdata = hi_addr ^ 8'hA5;

  function automatic ev_t mk_ev(input logic [1:0] k, input int c,
                                input logic [15:0] a, input logic [7:0] d);
    ev_t e;
    e.kind = k;
    e.cyc  = 32'(c);
    e.addr = a;
    e.data = d;
    return e;
  endfunction

  // Event monitor. Within a cycle, the order is OAM write, DMA read, active.
  always @(negedge clk) begin
    if (rst_n) begin
      if (oam_we)               log_q.push_back(mk_ev(K_OAM, cyc, {8'h00, oam_addr}, oam_wdata));
      if (dma_active && bus_rd) log_q.push_back(mk_ev(K_RD, cyc, bus_addr, 8'h00));
      if (dma_active)           log_q.push_back(mk_ev(K_ACT, cyc, 16'h0000, 8'h00));
    end
  end

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] eff_page(input logic [7:0] v);
    return (v >= 8'hE0) ? v - 8'h20 : v;
  endfunction

  // Expected events of a transfer triggered in cycle t with page v. Events at
  // or after cycle `cut` are dropped, and reads at or after `rd_cut` are dropped.
  task automatic model_dma(input int t, input logic [7:0] v, input int cut, input int rd_cut);
    logic [7:0] p;
    int         i;
    p = eff_page(v);
    for (int c = t + 1; c <= t + XFER + 2 && c < cut; c++) begin
      i = c - t - 3;
      if (i >= 0 && i < XFER) exp_q.push_back(mk_ev(K_OAM, c, 16'(i), ref_mem[{p, 8'(i)}]));
      i = c - t - 2;
      if (i >= 0 && i < XFER && c < rd_cut) exp_q.push_back(mk_ev(K_RD, c, {p, 8'(i)}, 8'h00));
      exp_q.push_back(mk_ev(K_ACT, c, 16'h0000, 8'h00));
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus helpers (no checking)
  // ---------------------------------------------------------------------------
  task automatic drive(input logic rd, input logic wr, input logic [15:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    cpu_rd = rd; cpu_wr = wr; cpu_addr = a; cpu_wdata = d;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 16'h0000, 8'h00);
  endtask

  task automatic preload(input logic [15:0] base, input bit rnd);
    logic [7:0] d;
    for (int i = 0; i < XFER; i++) begin
      d = rnd ? 8'($urandom) : (8'(i) ^ 8'h3C);
      drive(1'b0, 1'b1, base + 16'(i), d);
      ref_mem[base + 16'(i)] = d;
    end
    idle();
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0;
    cpu_rd = 1'b0; cpu_wr = 1'b1; cpu_addr = 16'hC123; cpu_wdata = 8'h5A;
    repeat (2) @(negedge clk);
    checks++;
    if (all_outs !== 70'd0) begin
      errors++; $display("FAIL reset_outputs got %h expected 0", all_outs);
    end
    cpu_wr = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 8'h00;
    #1 rst_n = 1'b1;
    drive(1'b1, 1'b0, 16'hFF46, 8'h00);
    @(negedge clk);
    checks++;
    if ({cpu_rdata, dma_active, hi_rd} !== {8'hFF, 1'b0, 1'b0}) begin
      errors++; $display("FAIL reset_readback got rdata=%h act=%b hi_rd=%b expected FF 0 0",
                         cpu_rdata, dma_active, hi_rd);
    end
    idle();
  endtask

  task automatic test_idle_passthrough();
    logic [15:0] a;
    logic [7:0]  d;
    logic        rd, wr, lo;
    drive(1'b0, 1'b1, 16'hC123, 8'h5A);
    ref_mem[16'hC123] = 8'h5A;
    @(negedge clk);
    checks++;
    if ({bus_wr, bus_rd, hi_wr, dma_active, bus_addr, bus_wdata} !== {4'b1000, 16'hC123, 8'h5A}) begin
      errors++; $display("FAIL idle_write got wr=%b rd=%b hw=%b act=%b addr=%h data=%h expected 1 0 0 0 C123 5A",
                         bus_wr, bus_rd, hi_wr, dma_active, bus_addr, bus_wdata);
    end
    drive(1'b1, 1'b0, 16'hC123, 8'h00);
    @(negedge clk);
    checks++;
    if ({bus_rd, bus_wr, bus_addr} !== {2'b10, 16'hC123}) begin
      errors++; $display("FAIL idle_read_strobe got rd=%b wr=%b addr=%h expected 1 0 C123", bus_rd, bus_wr, bus_addr);
    end
    drive(1'b1, 1'b0, 16'hC123, 8'h00);
    @(negedge clk);
    checks++;
    if (cpu_rdata !== 8'h5A) begin
      errors++; $display("FAIL idle_read_data got %h expected 5A", cpu_rdata);
    end
    drive(1'b1, 1'b0, 16'hFF85, 8'h00);
    @(negedge clk);
    checks++;
    if ({hi_rd, hi_wr, bus_rd, bus_wr, hi_addr, cpu_rdata} !== {4'b1000, 8'h85, 8'h20}) begin
      errors++; $display("FAIL idle_hi_read got hr=%b hw=%b br=%b bw=%b addr=%h rdata=%h expected 1 0 0 0 85 20",
                         hi_rd, hi_wr, bus_rd, bus_wr, hi_addr, cpu_rdata);
    end
    // Random accesses, with the source register kept out of the mix.
    for (int n = 0; n < 32; n++) begin
      a  = ($urandom_range(0, 1) == 1) ? {8'hFF, 8'($urandom)} : 16'($urandom_range(0, 16'hFEFF));
      if (a == 16'hFF46) a = 16'hFF47;
      d  = 8'($urandom);
      rd = 1'($urandom);
      wr = 1'($urandom);
      lo = (a < 16'hFF00);
      drive(rd, wr, a, d);
      if (wr && lo) ref_mem[a] = d;
      @(negedge clk);
      checks++;
      if ({bus_wr, bus_rd, hi_wr, hi_rd} !== {wr && lo, rd && !wr && lo, wr && !lo, rd && !wr && !lo}) begin
        errors++; $display("FAIL rand_route a=%h rd=%b wr=%b got bw=%b br=%b hw=%b hr=%b",
                           a, rd, wr, bus_wr, bus_rd, hi_wr, hi_rd);
      end
      if (lo && (rd || wr)) begin
        checks++;
        if (bus_addr !== a || (wr && bus_wdata !== d)) begin
          errors++; $display("FAIL rand_bus got addr=%h data=%h expected %h %h", bus_addr, bus_wdata, a, d);
        end
      end
      if (!lo && (rd || wr)) begin
        checks++;
        if (hi_addr !== a[7:0] || (wr && hi_wdata !== d) || (rd && !wr && cpu_rdata !== (a[7:0] ^ 8'hA5))) begin
          errors++; $display("FAIL rand_hi got addr=%h wdata=%h rdata=%h for a=%h d=%h", hi_addr, hi_wdata, cpu_rdata, a, d);
        end
      end
      if (rd && wr) begin
        checks++;
        if (cpu_rdata !== 8'hFF) begin
          errors++; $display("FAIL rand_rdwr got %h expected FF", cpu_rdata);
        end
      end
    end
    idle();
  endtask

  task automatic test_full_dma();
    int t, base, bad;
    preload(16'hC000, 1'b0);
    base = log_q.size();
    exp_q.delete();
    drive(1'b0, 1'b1, 16'hFF46, 8'hC0);
    t = cyc;
    model_dma(t, 8'hC0, NEVER, NEVER);
    for (int k = 1; k <= 170; k++) begin
      case (k)
        20:      drive(1'b1, 1'b0, 16'h8000, 8'h00);
        30:      drive(1'b0, 1'b1, 16'hFF90, 8'h11);
        40:      drive(1'b1, 1'b0, 16'hFF46, 8'h00);
        50:      drive(1'b0, 1'b1, 16'hC005, 8'h99);
        60:      drive(1'b1, 1'b1, 16'h8000, 8'h77);
        default: idle();
      endcase
      @(negedge clk);
      if (k == 20) begin
        checks++;
        if ({cpu_rdata, bus_wr, bus_rd, bus_addr} !== {8'hFF, 2'b01, 8'hC0, 8'd18}) begin
          errors++; $display("FAIL block_read got rdata=%h bw=%b br=%b addr=%h expected FF 0 1 C012",
                             cpu_rdata, bus_wr, bus_rd, bus_addr);
        end
      end
      if (k == 30) begin
        checks++;
        if ({hi_wr, hi_addr, hi_wdata, bus_wr} !== {1'b1, 8'h90, 8'h11, 1'b0}) begin
          errors++; $display("FAIL block_hi_write got hw=%b addr=%h data=%h bw=%b expected 1 90 11 0",
                             hi_wr, hi_addr, hi_wdata, bus_wr);
        end
      end
      if (k == 40) begin
        checks++;
        if (cpu_rdata !== 8'hC0) begin
          errors++; $display("FAIL busy_readback got %h expected C0", cpu_rdata);
        end
      end
      if (k == 50) begin
        checks++;
        if ({bus_wr, bus_addr} !== {1'b0, 8'hC0, 8'd48}) begin
          errors++; $display("FAIL block_write got bw=%b addr=%h expected 0 C030", bus_wr, bus_addr);
        end
      end
      if (k == 60) begin
        checks++;
        if ({cpu_rdata, bus_wr} !== {8'hFF, 1'b0}) begin
          errors++; $display("FAIL busy_rdwr got rdata=%h bw=%b expected FF 0", cpu_rdata, bus_wr);
        end
      end
    end
    checks++;
    if (dma_active !== 1'b0) begin
      errors++; $display("FAIL full_done got act=%b expected 0", dma_active);
    end
    checks++;
    if (log_q.size() - base != exp_q.size()) begin
      errors++; $display("FAIL full_count got %0d expected %0d", log_q.size() - base, exp_q.size());
    end
    bad = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (base + i >= log_q.size() || log_q[base + i] !== exp_q[i]) begin
        errors++;
        if (bad++ < 8) $display("FAIL full_event %0d got %h expected %h", i,
                                (base + i < log_q.size()) ? log_q[base + i] : ev_t'(0), exp_q[i]);
      end
    end
  endtask

  task automatic test_echo_fold();
    int t, base, bad;
    preload(16'hC100, 1'b1);
    base = log_q.size();
    exp_q.delete();
    drive(1'b0, 1'b1, 16'hFF46, 8'hE1);
    t = cyc;
    model_dma(t, 8'hE1, NEVER, NEVER);
    for (int k = 1; k <= 170; k++) begin
      if (k == 100 || k == 170) drive(1'b1, 1'b0, 16'hFF46, 8'h00);
      else idle();
      @(negedge clk);
      if (k == 100 || k == 170) begin
        checks++;
        if (cpu_rdata !== 8'hE1) begin
          errors++; $display("FAIL echo_readback k=%0d got %h expected E1", k, cpu_rdata);
        end
      end
    end
    checks++;
    if (log_q.size() - base != exp_q.size()) begin
      errors++; $display("FAIL echo_count got %0d expected %0d", log_q.size() - base, exp_q.size());
    end
    bad = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (base + i >= log_q.size() || log_q[base + i] !== exp_q[i]) begin
        errors++;
        if (bad++ < 8) $display("FAIL echo_event %0d got %h expected %h", i,
                                (base + i < log_q.size()) ? log_q[base + i] : ev_t'(0), exp_q[i]);
      end
    end
  endtask

  task automatic test_restart();
    int t1, t2, base, bad;
    preload(16'hD000, 1'b1);
    base = log_q.size();
    exp_q.delete();
    drive(1'b0, 1'b1, 16'hFF46, 8'hC0);
    t1 = cyc;
    for (int k = 1; k <= 51; k++) idle();
    drive(1'b0, 1'b1, 16'hFF46, 8'hD0);   // reads 0..49 have been issued
    t2 = cyc;
    model_dma(t1, 8'hC0, t2 + 1, t2);
    model_dma(t2, 8'hD0, NEVER, NEVER);
    @(negedge clk);
    checks++;
    if ({oam_we, oam_addr, bus_rd, dma_active} !== {1'b1, 8'd49, 1'b0, 1'b1}) begin
      errors++; $display("FAIL restart_commit got we=%b addr=%0d br=%b act=%b expected 1 49 0 1",
                         oam_we, oam_addr, bus_rd, dma_active);
    end
    for (int k = 1; k <= 170; k++) begin
      idle();
      @(negedge clk);
      if (k == 1) begin
        checks++;
        if ({dma_active, bus_rd, oam_we} !== 3'b100) begin
          errors++; $display("FAIL restart_start got act=%b br=%b we=%b expected 1 0 0", dma_active, bus_rd, oam_we);
        end
      end
    end
    checks++;
    if (log_q.size() - base != exp_q.size()) begin
      errors++; $display("FAIL restart_count got %0d expected %0d", log_q.size() - base, exp_q.size());
    end
    bad = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (base + i >= log_q.size() || log_q[base + i] !== exp_q[i]) begin
        errors++;
        if (bad++ < 8) $display("FAIL restart_event %0d got %h expected %h", i,
                                (base + i < log_q.size()) ? log_q[base + i] : ev_t'(0), exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int t, tr, base, bad;
    base = log_q.size();
    exp_q.delete();
    drive(1'b0, 1'b1, 16'hFF46, 8'hC0);
    t = cyc;
    for (int k = 1; k <= 81; k++) idle();
    @(posedge clk); #1;
    rst_n = 1'b0;                          // mid-cycle of read 80
    tr = cyc;
    model_dma(t, 8'hC0, tr, tr);
    #1;
    checks++;
    if (all_outs !== 70'd0) begin
      errors++; $display("FAIL reset_mid_outputs got %h expected 0", all_outs);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (all_outs !== 70'd0) begin
        errors++; $display("FAIL reset_mid_hold got %h expected 0", all_outs);
      end
    end
    #1 rst_n = 1'b1;
    drive(1'b1, 1'b0, 16'hFF46, 8'h00);
    @(negedge clk);
    checks++;
    if ({cpu_rdata, dma_active, oam_we} !== {8'hFF, 2'b00}) begin
      errors++; $display("FAIL reset_mid_readback got rdata=%h act=%b we=%b expected FF 0 0",
                         cpu_rdata, dma_active, oam_we);
    end
    for (int k = 0; k < 20; k++) idle();
    checks++;
    if (log_q.size() - base != exp_q.size()) begin
      errors++; $display("FAIL reset_mid_count got %0d expected %0d", log_q.size() - base, exp_q.size());
    end
    bad = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (base + i >= log_q.size() || log_q[base + i] !== exp_q[i]) begin
        errors++;
        if (bad++ < 8) $display("FAIL reset_mid_event %0d got %h expected %h", i,
                                (base + i < log_q.size()) ? log_q[base + i] : ev_t'(0), exp_q[i]);
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence
  // ---------------------------------------------------------------------------
  initial begin
    cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 8'h00;
    test_reset();
    test_idle_passthrough();
    test_full_dma();
    test_echo_fold();
    test_restart();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

endmodule
